// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the counter width used by every
// counter and decoder in the vga_timing slice.
package vga_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_DISP = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_DISP = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;
   localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; exposes its next value so callers can decode registered
// outputs that line up with the count they describe.
module mod_counter
   import vga_pkg::*;
#(
   parameter int MODULUS = DEF_H_TOTAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wrap       = en && (count >= LAST);
      count_next = count;
      // Out-of-range values recover to 0 even while the counter is not enabled.
      if (count > LAST || wrap)
         count_next = '0;
      else if (en)
         count_next = count + CNT_W'(1);
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered syncs, valid and
// frame_start. Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_DISP = DEF_H_DISP,
   parameter int H_FP   = DEF_H_FP,
   parameter int H_SYNC = DEF_H_SYNC,
   parameter int H_BP   = DEF_H_BP,
   parameter int V_DISP = DEF_V_DISP,
   parameter int V_FP   = DEF_V_FP,
   parameter int V_SYNC = DEF_V_SYNC,
   parameter int V_BP   = DEF_V_BP
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hsync,
   output logic             vsync,
   output logic             valid,
   output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0]       frame_cnt
`endif
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISP);
   localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISP);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_DISP + H_FP);
   localparam logic [CNT_W-1:0] HS_STOP    = CNT_W'(H_DISP + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_DISP + V_FP);
   localparam logic [CNT_W-1:0] VS_STOP    = CNT_W'(V_DISP + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             h_wrap;
   logic             v_wrap;

   mod_counter #(.MODULUS(H_TOTAL)) u_h_counter (
      .clk        (clk),
      .reset      (reset),
      .en         (1'b1),
      .count      (h_cnt),
      .count_next (h_next),
      .wrap       (h_wrap)
   );

   mod_counter #(.MODULUS(V_TOTAL)) u_v_counter (
      .clk        (clk),
      .reset      (reset),
      .en         (h_wrap),
      .count      (v_cnt),
      .count_next (v_next),
      .wrap       (v_wrap)
   );

   // Decoding the next counter values keeps these flops aligned with h_cnt/v_cnt.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         valid       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= !(h_next >= HS_START && h_next < HS_STOP);
         vsync       <= !(v_next >= VS_START && v_next < VS_STOP);
         valid       <= (h_next < H_VIS) && (v_next < V_VIS);
         frame_start <= h_wrap && v_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= 8'd0;
      else if (h_wrap && v_wrap)
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_DISP, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width, pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch, pixels (H_TOTAL = sum of H_* = 800).
REQ-005 Parameter V_DISP, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width, lines.
REQ-008 Parameter V_BP, 33, vertical back porch, lines (V_TOTAL = sum of V_* = 525).
REQ-009 clk  input  1  pixel clock (system clock divided by 4, nominally 25 MHz); all logic on its rising edge.
REQ-010 reset  input  1  reset, synchronous, active-high.
REQ-011 h_cnt  output  10  current pixel column, 0..H_TOTAL-1.
REQ-012 v_cnt  output  10  current line, 0..V_TOTAL-1.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 valid  output  1  high when (h_cnt, v_cnt) is inside the visible area.
REQ-016 frame_start  output  1  one-cycle pulse when counters reach (0,0).
REQ-017 frame_cnt  output  8  frame counter, present only with VGA_FRAME_CNT_EN.

Function
REQ-018 h_cnt SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-019 v_cnt SHALL increment by 1 only on the cycle h_cnt wraps and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-020 hsync SHALL be 0 exactly for h_cnt in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] (656..751), else 1.
REQ-021 vsync SHALL be 0 exactly for v_cnt in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] (490..491), else 1.
REQ-022 valid SHALL be 1 exactly when h_cnt < H_DISP and v_cnt < V_DISP.
REQ-023 hsync, vsync, valid, frame_start SHALL be registered, decoded from next-state counter values, so they are cycle-aligned with the h_cnt/v_cnt they describe (zero relative latency, no combinational path from counters to outputs).
REQ-024 frame_start SHALL be 1 for exactly one cycle per frame, the cycle h_cnt=0 and v_cnt=0 following a wrap from (799,524).
REQ-025 Counters SHALL never take values >= their TOTAL; any out-of-range value SHALL wrap to 0 on the next edge.

Reset
REQ-026 While reset is high: h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=0, frame_start=0, frame_cnt=0.
REQ-027 First edge with reset low SHALL give h_cnt=1, v_cnt=0, valid=1; the (0,0) pixel of the first frame is deliberately masked and no frame_start is issued for it.
REQ-028 Reset asserted mid-frame SHALL take effect on the next edge regardless of counter position, with no sync glitch (syncs forced to 1).

Configuration
REQ-029 Macro VGA_FRAME_CNT_EN defined: frame_cnt port exists and increments by 1 on each frame_start cycle, wrapping 255->0.
REQ-030 Macro VGA_FRAME_CNT_EN undefined: frame_cnt port and its register are absent; all other behaviour identical.

Structure
REQ-031 Shared package vga_pkg SHALL hold the default timing constants (H_*/V_* and totals) and the 10-bit counter width constant.
REQ-032 One sub-module mod_counter (modulus parameter, enable input, count and wrap outputs) SHALL be instantiated twice, horizontal and vertical.

Verification
REQ-033 Release reset, run 800 cycles -> h_cnt 1..799 then 0, v_cnt steps 0->1 exactly at the wrap, no frame_start.
REQ-034 Run one full frame (420000 cycles) -> exactly 480 lines with 640 valid cycles each (307200 valid cycles total), 525 hsync pulses of 96 cycles each.
REQ-035 Frame boundary at (799,524) -> next cycle (0,0) with frame_start=1 for one cycle and vsync=1; vsync low only on lines 490 and 491.
REQ-036 Assert reset at h_cnt=700, v_cnt=491 (hsync and vsync both low) -> next edge all outputs at reset values, hsync=vsync=1.
REQ-037 With VGA_FRAME_CNT_EN, run 256 frames -> frame_cnt increments on every frame_start, returns to 0 after frame 256; without macro, the same bench compiles with frame_cnt checks excluded.
